// File: rtl/multiply_divide_unit.sv
// ---------------------------------------------------------------------------
// multiply_divide_unit
//   Owns the architectural HI/LO pair for the EX stage. Runs mult/multu/
//   div/divu as multi-cycle operations, services mthi/mtlo/mfhi/mflo and
//   reports busy so the hazard unit can stall dependent instructions.
//   An in-flight operation can be squashed with flush.
//
// Parameters
//   WIDTH         operand and HI/LO width
//   MULT_LATENCY  busy cycles for mult/multu (>= 1)
//   DIV_LATENCY   busy cycles for div/divu   (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   valid      in   EX-stage instruction is real (not a bubble)
//   flush      in   abort any in-flight operation
//   ctrl[4:0]  in   {launch, divide, unsigned, move_to, target_lo}
//   A, B       in   rs / rt operands
//   busy       out  operation in flight (registered)
//   start      out  accepted launch this cycle (combinational)
//   HI, LO     out  architectural HI/LO registers
//   read_data  out  ctrl[0] ? LO : HI (combinational)
//
// Build option
//   MDU_DIV_ZERO_FAST_EN  when defined, a divide accepted with B == 0
//                         finishes after a single busy cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | counter == 0, accepts launches and move-to writes
// RUN   | counter  > 0, operation in flight, counting down to 1
// ---------------------------------------------------------------------------
module multiply_divide_unit #(
  parameter int WIDTH        = 32,
  parameter int MULT_LATENCY = 5,
  parameter int DIV_LATENCY  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             flush,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             start,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] read_data
);

  localparam int MAX_LAT = (DIV_LATENCY > MULT_LATENCY) ? DIV_LATENCY : MULT_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LATENCY);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic               div_q,   div_d;
  logic               uns_q,   uns_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;

  logic               run;
  logic               move_wr;
  logic [2*WIDTH-1:0] result;

  // -------------------------------------------------------------------------
  // Result datapath, always from the latched operands.
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    // The low 2*WIDTH bits of the product of sign-extended operands equal
    // the signed product, so one multiplier serves both mult and multu.
    a_ext = uns_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext = uns_q ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;

    // Signed divide on magnitudes. |MIN| wraps to 2^(WIDTH-1) which is still
    // correct as an unsigned magnitude, so MIN / -1 yields LO=MIN, HI=0.
    a_neg  = ~uns_q & a_q[WIDTH-1];
    b_neg  = ~uns_q & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    // Divisor of zero never reaches HI/LO; keep the divider well defined.
    b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    result = div_q ? {rem, quo} : prod;
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      uns_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      uns_q   <= uns_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    uns_d   = uns_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = ctrl[3] ? DIV_CNT : MULT_CNT;
`ifdef MDU_DIV_ZERO_FAST_EN
          if (ctrl[3] && (B == '0)) begin
            cnt_d = CNT_ONE;
          end
`endif
          a_d   = A;
          b_d   = B;
          div_d = ctrl[3];
          uns_d = ctrl[2];
        end else if (move_wr) begin
          if (ctrl[0]) begin
            lo_d = A;
          end else begin
            hi_d = A;
          end
        end
      end

      RUN: begin
        if (flush) begin
          // Flush wins over a coinciding completion edge.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!(div_q && (b_q == '0))) begin
            {hi_d, lo_d} = result;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    run       = (state_q == RUN);
    busy      = run;
    start     = valid & ctrl[4] & ~run & ~flush;
    move_wr   = valid & ~ctrl[4] & ctrl[1] & ~run & ~flush;
    HI        = hi_q;
    LO        = lo_q;
    read_data = ctrl[0] ? lo_q : hi_q;
  end

endmodule

// File: tb/tb_multiply_divide_unit.sv
module tb_multiply_divide_unit;

  logic        clk;
  logic        reset, valid, flush;
  logic [4:0]  ctrl;
  logic [31:0] a, b;
  logic        busy, start;
  logic [31:0] hi, lo, rd;

  logic        reset2, valid2, flush2;
  logic [4:0]  ctrl2;
  logic [15:0] a2, b2;
  logic        busy2, start2;
  logic [15:0] hi2, lo2, rd2;

  int tests;
  int failures;
  logic [31:0] hi_m, lo_m;
  logic [63:0] sb_q[$];

  multiply_divide_unit #(.WIDTH(32), .MULT_LATENCY(5), .DIV_LATENCY(10)) dut (
    .clk(clk), .reset(reset), .valid(valid), .flush(flush), .ctrl(ctrl),
    .A(a), .B(b), .busy(busy), .start(start), .HI(hi), .LO(lo), .read_data(rd)
  );

  multiply_divide_unit #(.WIDTH(16), .MULT_LATENCY(1), .DIV_LATENCY(3)) dut16 (
    .clk(clk), .reset(reset2), .valid(valid2), .flush(flush2), .ctrl(ctrl2),
    .A(a2), .B(b2), .busy(busy2), .start(start2), .HI(hi2), .LO(lo2), .read_data(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog");
  end

`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 10;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 32-bit instance.
  function automatic logic [63:0] model(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] h, input logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    if (!c[3]) begin
      if (c[2]) begin
        up = {32'b0, x} * {32'b0, y};
        return up;
      end
      sp = longint'($signed(x)) * longint'($signed(y));
      return sp;
    end
    if (y == 32'd0) return {h, l};
    if (c[2]) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sx = x;
    sy = y;
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  task automatic move_to(input logic lo_sel, input logic [31:0] d);
    valid = 1'b1;
    ctrl  = {3'b000, 1'b1, lo_sel};
    a     = d;
    step();
    valid = 1'b0;
    ctrl  = 5'd0;
    a     = 32'd0;
    if (lo_sel) lo_m = d; else hi_m = d;
  endtask

  task automatic launch(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                        input string tag, input bit push);
    valid = 1'b1;
    ctrl  = c;
    a     = x;
    b     = y;
    #1;
    check({tag, " start"}, 64'(start), 64'd1);
    if (push) sb_q.push_back(model(c, x, y, hi_m, lo_m));
    step();
    valid = 1'b0;
    ctrl  = 5'd0;
    a     = 32'd0;
    b     = 32'd0;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int          n;
    logic [63:0] e;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " pending"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " hilo"}, {hi, lo}, e);
      hi_m = e[63:32];
      lo_m = e[31:0];
    end
  endtask

  initial begin
    tests = 0; failures = 0;
    hi_m = 32'd0; lo_m = 32'd0;
    reset = 1'b0; valid = 1'b0; flush = 1'b0; ctrl = 5'd0; a = 32'd0; b = 32'd0;
    reset2 = 1'b0; valid2 = 1'b0; flush2 = 1'b0; ctrl2 = 5'd0; a2 = 16'd0; b2 = 16'd0;

    repeat (2) step();
    reset = 1'b1;
    reset2 = 1'b1;
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset16 hilo", 64'({hi2, lo2}), 64'd0);
    check("reset16 busy", 64'(busy2), 64'd0);

    move_to(1'b0, 32'h1234_5678);
    check("mthi", 64'(hi), 64'h1234_5678);
    move_to(1'b1, 32'hCAFE_BABE);
    check("mtlo", 64'(lo), 64'hCAFE_BABE);
    check("mtlo hi kept", 64'(hi), 64'h1234_5678);
    ctrl = 5'b00001; #1;
    check("mflo read_data", 64'(rd), 64'hCAFE_BABE);
    ctrl = 5'b00000; #1;
    check("mfhi read_data", 64'(rd), 64'h1234_5678);

    launch(5'b10000, 32'hFFFF_FFFF, 32'd2, "mult", 1'b1);
    wait_done(5, "mult");
    check("mult literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    launch(5'b10100, 32'hFFFF_FFFF, 32'd2, "multu", 1'b1);
    wait_done(5, "multu");
    check("multu literal", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    launch(5'b11000, 32'hFFFF_FFF9, 32'd2, "div", 1'b1);
    wait_done(10, "div");
    check("div literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(5'b11000, 32'h8000_0000, 32'hFFFF_FFFF, "div min", 1'b1);
    wait_done(10, "div min");
    check("div min literal", {hi, lo}, 64'h0000_0000_8000_0000);

    // divu squashed in its fourth busy cycle
    launch(5'b11100, 32'd100, 32'd7, "divu flush", 1'b0);
    repeat (3) step();
    flush = 1'b1; #1;
    check("flush busy before", 64'(busy), 64'd1);
    step();
    flush = 1'b0;
    check("flush busy after", 64'(busy), 64'd0);
    check("flush hilo kept", {hi, lo}, {hi_m, lo_m});

    // launch and move-to while busy are ignored
    launch(5'b10000, 32'd7, 32'hFFFF_FFFD, "mult busy", 1'b1);
    valid = 1'b1; ctrl = 5'b11100; a = 32'd99; b = 32'd4; #1;
    check("launch while busy start", 64'(start), 64'd0);
    step();
    ctrl = 5'b00010; a = 32'hDEAD_BEEF;
    step();
    valid = 1'b0; ctrl = 5'd0; a = 32'd0; b = 32'd0;
    wait_done(3, "mult busy");

    // flush coinciding with the completion edge
    launch(5'b10000, 32'd3, 32'd5, "flush at done", 1'b0);
    repeat (4) step();
    flush = 1'b1; #1;
    check("flush at done busy before", 64'(busy), 64'd1);
    step();
    flush = 1'b0;
    check("flush at done busy after", 64'(busy), 64'd0);
    check("flush at done hilo kept", {hi, lo}, {hi_m, lo_m});

    // launch with flush high in the same cycle
    valid = 1'b1; ctrl = 5'b10000; a = 32'd3; b = 32'd5; flush = 1'b1; #1;
    check("launch with flush start", 64'(start), 64'd0);
    step();
    valid = 1'b0; ctrl = 5'd0; flush = 1'b0;
    check("launch with flush busy", 64'(busy), 64'd0);

    // divide by zero, then a back-to-back launch
    move_to(1'b0, 32'hAAAA_5555);
    move_to(1'b1, 32'hAAAA_5555);
    launch(5'b11100, 32'd1234, 32'd0, "divu zero", 1'b1);
    wait_done(DIV0_LAT, "divu zero");
    check("divu zero literal", {hi, lo}, 64'hAAAA_5555_AAAA_5555);
    launch(5'b10100, 32'h0001_0000, 32'h0001_0000, "b2b multu", 1'b1);
    wait_done(5, "b2b multu");

    // 16-bit instance, latencies 1 and 3
    valid2 = 1'b1; ctrl2 = 5'b10000; a2 = 16'h8000; b2 = 16'h8000; #1;
    check("w16 mult start", 64'(start2), 64'd1);
    step();
    valid2 = 1'b0; ctrl2 = 5'd0;
    check("w16 mult busy", 64'(busy2), 64'd1);
    step();
    check("w16 mult done", 64'(busy2), 64'd0);
    check("w16 mult hilo", 64'({hi2, lo2}), 64'h4000_0000);
    ctrl2 = 5'b00001; #1;
    check("w16 read_data", 64'(rd2), 64'h0000);
    ctrl2 = 5'd0;
    valid2 = 1'b1; ctrl2 = 5'b11000; a2 = 16'd100; b2 = 16'd7;
    step();
    valid2 = 1'b0; ctrl2 = 5'd0;
    check("w16 div busy", 64'(busy2), 64'd1);
    reset2 = 1'b0;
    step();
    reset2 = 1'b1;
    check("w16 reset hilo", 64'({hi2, lo2}), 64'd0);
    check("w16 reset busy", 64'(busy2), 64'd0);
    repeat (3) step();
    check("w16 reset no write", 64'({hi2, lo2}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Parametrised multiply/divide unit that owns the HI/LO register pair for the EX stage. It consumes the 5-bit `Multiply_ctrl` word the EX controller produces, runs mult/multu/div/divu over a configurable number of cycles, services mthi/mtlo/mfhi/mflo, and reports `busy` to the hazard unit so dependent instructions stall. It also adds an in-flight abort (`flush`) for exception/branch squash.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_LATENCY`, 5: cycles `busy` stays high for mult/multu; must be ≥1.
- `DIV_LATENCY`, 10: cycles `busy` stays high for div/divu; must be ≥1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `valid`  in  1  EX-stage instruction is real (not a bubble).
- `flush`  in  1  abort any in-flight operation.
- `ctrl`  in  5  {launch, divide, unsigned, move_to, target_lo}; all zero for non-MDU instructions.
- `A`  in  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo data.
- `B`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  operation in flight.
- `start`  out  1  combinational: this cycle's instruction is an accepted launch.
- `HI`, `LO`  out  WIDTH  architectural HI/LO registers.
- `read_data`  out  WIDTH  `ctrl[0] ? LO : HI` (mfhi/mflo result), combinational.

## Operation
- Accepted launch: `valid & ctrl[4] & ~busy & ~flush`; `start` equals this term.
- Launch while `busy`, or with `flush` high: ignored, no state change.
- On accept: operands latched; counter loaded with `ctrl[3] ? DIV_LATENCY : MULT_LATENCY`; pending result computed from latched operands.
- mult (`ctrl[3:2]=00`): {HI,LO} ← signed A×B, 2·WIDTH bits. multu (`01`): unsigned product.
- div (`10`): LO ← quotient truncated toward zero, HI ← remainder with sign of dividend. divu (`11`): unsigned.
- Signed MIN÷(−1): LO ← MIN, HI ← 0.
- Divide by zero: HI/LO unchanged at completion; latency as per Configuration.
- Move-to: `valid & ~ctrl[4] & ctrl[1] & ~busy & ~flush` writes A into LO (`ctrl[0]=1`) or HI (`ctrl[0]=0`) at the edge. Move-to while `busy` is ignored (the hazard unit stalls it).
- `flush` while `busy`: counter cleared, pending result discarded, HI/LO keep pre-launch values.
- Simultaneous `flush` and completion edge (counter=1): flush wins, HI/LO not written.
- States: IDLE (counter=0) and RUN (counter>0). IDLE→RUN on accepted launch; RUN→RUN with decrement while counter>1; RUN→IDLE on the counter=1 edge (HI/LO written) or on `flush`.

## Timing
- Reset values: HI=0, LO=0, counter=0, `busy`=0. Reset mid-operation discards the pending result.
- Launch accepted at edge E0. `busy`=1 for exactly N cycles after E0 (N = selected latency). HI/LO are written at edge E0+N, the same edge at which `busy` falls.
- New HI/LO are therefore visible whenever `busy` reads 0.
- Back-to-back: a launch is accepted in the first cycle `busy` reads 0.
- Move-to: one-cycle write; the value is visible in the next cycle.
- `read_data` and `start` have zero latency; every other output is registered.

## Configuration
- `MDU_DIV_ZERO_FAST_EN` defined: a div/divu accepted with B=0 loads counter=1, so `busy` is high for 1 cycle and HI/LO are unchanged.
- Not defined: divide by zero runs the full `DIV_LATENCY` and HI/LO are unchanged.

## Test plan
- Reset low for 2 cycles, then high → HI=LO=0, `busy`=0. Then mthi 0x12345678, mtlo 0xCAFEBABE → next cycle HI=0x12345678, LO=0xCAFEBABE; `read_data` follows `ctrl[0]`.
- mult A=0xFFFFFFFF (−1), B=2 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=−7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). div 0x80000000÷0xFFFFFFFF → LO=0x80000000, HI=0.
- Launch divu, then assert `flush` at cycle 4 → `busy` falls the next cycle; HI/LO retain prior values. Second launch attempted while `busy` → ignored, and completion carries the first operation's result.
- divu B=0 with HI=LO=0xAAAA5555 → HI/LO unchanged; `busy` lasts 10 cycles without `MDU_DIV_ZERO_FAST_EN`, 1 cycle with it.
- Parameter sweep WIDTH=16, MULT_LATENCY=1, DIV_LATENCY=3: mult 0x8000×0x8000 → after 1 cycle HI=0x4000, LO=0x0000. Reset asserted mid-divide → HI=LO=0 and `busy`=0 next cycle.
